// File: rtl/cdc_src_arbiter_clearable.sv
// cdc_src_arbiter_clearable: round-robin arbiter feeding one clearable CDC source port,
// with a local clear sequencer that drains, pulses clear and tracks clear-pending.
module cdc_src_arbiter_clearable #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          cdc_valid_o,
    output logic [DATA_WIDTH-1:0]         cdc_data_o,
    output logic [IDX_WIDTH-1:0]          cdc_idx_o,
    input  logic                          cdc_ready_i,
    output logic                          cdc_clear_o,
    input  logic                          cdc_clear_pending_i,
    input  logic                          clear_req_i,
    output logic                          clear_busy_o,
    output logic                          clear_done_o,
    output logic                          drop_o
);
    typedef enum logic [2:0] {IDLE, DRAIN, CLEAR, WAIT_SET, WAIT_CLR} state_e;

    state_e                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_WIDTH-1:0]  out_idx_q, out_idx_d;
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  hs, load_en, found;
    logic [IDX_WIDTH-1:0]  winner;
    logic [IDX_WIDTH:0]    cand;

    assign hs      = out_valid_q & cdc_ready_i;
    assign load_en = (state_q == IDLE) & ~clear_req_i & ~cdc_clear_pending_i & (~out_valid_q | cdc_ready_i);

    assign cdc_valid_o  = out_valid_q;
    assign cdc_data_o   = out_data_q;
    assign cdc_idx_o    = out_idx_q;
    assign cdc_clear_o  = (state_q == CLEAR);
    assign clear_busy_o = (state_q != IDLE);

    // Scan offsets from farthest to nearest so the closest valid requester to ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IDX_WIDTH+1)'(k);
            if (cand >= (IDX_WIDTH+1)'(NUM_REQ)) cand = cand - (IDX_WIDTH+1)'(NUM_REQ);
            if (req_valid_i[cand[IDX_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        ptr_d        = ptr_q;
        req_ready_o  = '0;
        drop_o       = 1'b0;
        clear_done_o = 1'b0;
        if (load_en && found) begin
            req_ready_o[winner] = 1'b1;
            out_valid_d         = 1'b1;
            out_data_d          = req_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
            out_idx_d           = winner;
            ptr_d               = (winner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (hs) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE:     if (clear_req_i) state_d = (out_valid_q && !cdc_ready_i) ? DRAIN : CLEAR;
            DRAIN: begin
                if (hs) begin
                    state_d = CLEAR;
                end else if (cdc_clear_pending_i) begin
                    out_valid_d = 1'b0;
                    drop_o      = 1'b1;
                    state_d     = CLEAR;
                end
            end
            CLEAR:    state_d = WAIT_SET;
            WAIT_SET: if (cdc_clear_pending_i) state_d = WAIT_CLR;
            WAIT_CLR: begin
                if (!cdc_clear_pending_i) begin
                    clear_done_o = 1'b1;
                    state_d      = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (!(cdc_clear_o && cdc_valid_o));
    end
endmodule

// File: doc/cdc_src_arbiter_clearable.md
Name: cdc_src_arbiter_clearable

Overview:
Source-side controller for one clearable 2-phase CDC channel. Round-robin arbitrates NUM_REQ ready/valid requesters onto the single CDC source port through a one-entry output register, and tags each beat with the winner index. Sequences a local clear: drain the buffered beat, pulse the CDC clear, then track the CDC's clear-pending flag until the crossing is usable again. Sits in the source clock domain directly in front of the CDC's src_* ports.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, payload width per requester
IDX_WIDTH, max(1,$clog2(NUM_REQ)), derived; width of cdc_idx_o

Ports:
clk_i  in  1  clock (CDC source clock)
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  NUM_REQ  per-requester valid
req_data_i  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  out  NUM_REQ  per-requester ready; at most one bit high per cycle
cdc_valid_o  out  1  to CDC src_valid_i
cdc_data_o  out  DATA_WIDTH  to CDC src_data_i
cdc_idx_o  out  IDX_WIDTH  index of requester owning the current beat
cdc_ready_i  in  1  from CDC src_ready_o
cdc_clear_o  out  1  to CDC src_clear_i
cdc_clear_pending_i  in  1  from CDC src_clear_pending_o
clear_req_i  in  1  single-cycle local clear request
clear_busy_o  out  1  high whenever FSM is not IDLE
clear_done_o  out  1  one-cycle pulse when a clear sequence completes
drop_o  out  1  one-cycle pulse when a buffered beat is discarded

Behaviour:
- Reset (rst_ni=0 at posedge): state=IDLE, out_valid_q=0, out_data_q=0, out_idx_q=0, rr pointer=0. All outputs 0.
- Output register: cdc_valid_o=out_valid_q, cdc_data_o=out_data_q, cdc_idx_o=out_idx_q; all registered. The contents stay stable while valid and not ready.
- Handshake: hs = out_valid_q & cdc_ready_i.
- load_en = (state==IDLE) & !clear_req_i & !cdc_clear_pending_i & (!out_valid_q | cdc_ready_i).
- Arbitration, when load_en: the winner is the first requester with valid set, searching from pointer upward and wrapping modulo NUM_REQ.
  - req_ready_o[winner]=1 that cycle, combinationally, and the beat is captured into the register.
  - pointer <= (winner+1) mod NUM_REQ.
  - Latency: req handshake to cdc_valid_o is 1 cycle.
  - With no valid requester, the pointer is unchanged. On hs without a load, out_valid_q <= 0.
- A remote clear (cdc_clear_pending_i=1 while IDLE) blocks new loads only. A buffered beat is held and re-presented after pending falls; it is never dropped.
- FSM:
  - IDLE: on clear_req_i=1, go to DRAIN if (out_valid_q & !cdc_ready_i), else go to CLEAR (a beat handshaking this cycle completes normally). clear_req_i outside IDLE is ignored.
  - DRAIN: hold the beat. On hs, go to CLEAR. Else if cdc_clear_pending_i=1: out_valid_q<=0, drop_o=1, go to CLEAR.
  - CLEAR: cdc_clear_o=1 for exactly this cycle; cdc_valid_o is guaranteed 0. Go to WAIT_SET.
  - WAIT_SET: wait for cdc_clear_pending_i=1, then go to WAIT_CLR. If pending was already 1 in CLEAR, leave after one cycle.
  - WAIT_CLR: on cdc_clear_pending_i=0, clear_done_o=1 and go to IDLE. Arbitration resumes the following cycle.
- The rr pointer is not reset by a clear sequence.
- Synchronous reset mid-sequence returns to IDLE with no clear_done_o or drop_o pulse.
- An assertion checks: cdc_clear_o & cdc_valid_o never both high.

Test Plan:
1. Reset, then all 4 requesters valid every cycle with cdc_ready_i=1 -> cdc_idx_o sequence 0,1,2,3,0 on consecutive cycles. The first cdc_valid_o appears 1 cycle after the first req_ready_o.
2. Requester 2 sends 0xA5 with cdc_ready_i=0 for 5 cycles -> cdc_valid_o=1, data=0xA5, idx=2 stable all 5 cycles; req_ready_o=0 throughout; the beat is accepted on the cycle ready rises.
3. Empty buffer, clear_req_i at cycle 0, pending high cycles 2-6 -> cdc_clear_o=1 only at cycle 1; clear_busy_o=1 cycles 1-7; clear_done_o at cycle 7; loads resume at cycle 8.
4. Buffered 0x3C with ready=0, clear_req_i pulse, ready rises 3 cycles later -> 0x3C handshakes; cdc_clear_o the next cycle; drop_o never asserts.
5. In DRAIN, pending rises (remote clear) with ready=0 -> drop_o=1 for one cycle; cdc_valid_o=0 next; cdc_clear_o follows; clear_done_o when pending falls.
6. rst_ni=0 in WAIT_CLR -> next cycle all outputs 0, state IDLE. A later clear_req_i runs a complete sequence normally.
